// File: rtl/snn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snn_pkg : shared state encoding, pixel constant, rectifier helper  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package snn_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_HID_MAC   = 4'd1,
    S_HID_DRAIN = 4'd2,
    S_HID_LUT   = 4'd3,
    S_HID_WR    = 4'd4,
    S_OUT_MAC   = 4'd5,
    S_OUT_DRAIN = 4'd6,
    S_OUT_LUT   = 4'd7,
    S_OUT_CMP   = 4'd8,
    S_DONE      = 4'd9
  } snn_state_t;

  localparam logic [7:0] PIX_HI = 8'h7F;

  // Drops FRAC LSBs, saturates to a signed LUT_AW-bit range and flips the
  // MSB so the signed result indexes the LUT as 0..2^LUT_AW-1.
  function automatic logic [31:0] snn_rectify(input logic signed [63:0] acc,
                                              input int frac,
                                              input int lut_aw);
    logic signed [63:0] hi;
    logic signed [63:0] r;
    logic [63:0]        mask;
    logic [63:0]        half;
    hi   = acc >>> (frac + lut_aw - 1);
    r    = acc >>> frac;
    mask = (64'd1 << lut_aw) - 64'd1;
    half = 64'd1 << (lut_aw - 1);
    if (hi == 64'sd0 || hi == -64'sd1) begin
      snn_rectify = 32'((r ^ half) & mask);
    end else if (acc[63]) begin
      snn_rectify = 32'd0;
    end else begin
      snn_rectify = 32'(mask);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_core_param_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snn_mac : signed multiply-accumulate, synchronous clear and enable |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snn_mac #(
  parameter int W_W   = 8,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [W_W:0]     a_i,
  input  logic signed [W_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int P_W = 2 * W_W + 1;

  logic signed [P_W-1:0]   prod_w;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod_w = P_W'(a_i) * P_W'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/snn_core_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snn_core_param : two-layer binary-input SNN inference with argmax  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snn_core_param
  import snn_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int W_W    = 8,
  parameter int ACC_W  = 26,
  parameter int FRAC   = 7,
  parameter int LUT_AW = 11,
  localparam int OUT_W  = $clog2(N_OUT),
  localparam int IN_AW  = $clog2(N_IN),
  localparam int HID_AW = $clog2(N_HID)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic [IN_AW-1:0]        in_addr_o,
  input  logic                    in_q_i,
  output logic [HID_AW+IN_AW-1:0] hw_addr_o,
  input  logic [W_W-1:0]          hw_q_i,
  output logic [OUT_W+HID_AW-1:0] ow_addr_o,
  input  logic [W_W-1:0]          ow_q_i,
  output logic [LUT_AW-1:0]       lut_addr_o,
  input  logic [W_W-1:0]          lut_q_i,
  output logic [OUT_W-1:0]        digit_o,
  output logic                    done_o,
  output logic                    busy_o
);

  snn_state_t          state_q, state_d;
  logic [IN_AW-1:0]    in_idx_q, in_idx_d;
  logic [HID_AW-1:0]   hid_idx_q, hid_idx_d;
  logic [OUT_W-1:0]    out_idx_q, out_idx_d;
  logic [W_W-1:0]      best_val_q, best_val_d;
  logic [OUT_W-1:0]    best_idx_q, best_idx_d;
  logic [OUT_W-1:0]    digit_q, digit_d;
  logic                vld_q;
  logic [W_W-1:0]      hid_ram_q [N_HID];
  logic [W_W-1:0]      hid_rd_q;

  logic                    acc_clr_w;
  logic                    ram_we_w;
  logic                    take_w;
  logic                    hid_layer_w;
  logic signed [W_W:0]     a_w;
  logic signed [W_W-1:0]   b_w;
  logic signed [ACC_W-1:0] acc_w;
  logic signed [63:0]      acc_ext_w;
  logic [LUT_AW-1:0]       rect_w;

  // Operands arrive one cycle after their address, so the MAC is enabled
  // on the cycle following every MAC-state cycle (covers the drain cycle).
  assign hid_layer_w = (state_q == S_HID_MAC) || (state_q == S_HID_DRAIN);
  assign a_w = hid_layer_w ? (W_W+1)'(in_q_i ? PIX_HI : 8'h00)
                           : {1'b0, hid_rd_q};
  assign b_w = hid_layer_w ? hw_q_i : ow_q_i;

  snn_mac #(
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (acc_clr_w),
    .en_i  (vld_q),
    .a_i   (a_w),
    .b_i   (b_w),
    .acc_o (acc_w)
  );

  assign acc_ext_w = 64'(acc_w);
  assign rect_w    = LUT_AW'(snn_rectify(acc_ext_w, FRAC, LUT_AW));
  assign take_w    = (out_idx_q == '0) || (lut_q_i > best_val_q);

  always_comb begin
    state_d    = state_q;
    in_idx_d   = in_idx_q;
    hid_idx_d  = hid_idx_q;
    out_idx_d  = out_idx_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    acc_clr_w  = 1'b0;
    ram_we_w   = 1'b0;
    in_addr_o  = '0;
    hw_addr_o  = '0;
    ow_addr_o  = '0;
    lut_addr_o = '0;
    case (state_q)
      S_IDLE: begin
        acc_clr_w  = 1'b1;
        in_idx_d   = '0;
        hid_idx_d  = '0;
        out_idx_d  = '0;
        best_val_d = '0;
        best_idx_d = '0;
        if (start_i) state_d = S_HID_MAC;
      end
      S_HID_MAC: begin
        in_addr_o = in_idx_q;
        hw_addr_o = {hid_idx_q, in_idx_q};
        if (in_idx_q == IN_AW'(N_IN - 1)) begin
          in_idx_d = '0;
          state_d  = S_HID_DRAIN;
        end else begin
          in_idx_d = in_idx_q + IN_AW'(1);
        end
      end
      S_HID_DRAIN: state_d = S_HID_LUT;
      S_HID_LUT: begin
        lut_addr_o = rect_w;
        state_d    = S_HID_WR;
      end
      S_HID_WR: begin
        ram_we_w  = 1'b1;
        acc_clr_w = 1'b1;
        if (hid_idx_q == HID_AW'(N_HID - 1)) begin
          hid_idx_d = '0;
          state_d   = S_OUT_MAC;
        end else begin
          hid_idx_d = hid_idx_q + HID_AW'(1);
          state_d   = S_HID_MAC;
        end
      end
      S_OUT_MAC: begin
        ow_addr_o = {out_idx_q, hid_idx_q};
        if (hid_idx_q == HID_AW'(N_HID - 1)) begin
          hid_idx_d = '0;
          state_d   = S_OUT_DRAIN;
        end else begin
          hid_idx_d = hid_idx_q + HID_AW'(1);
        end
      end
      S_OUT_DRAIN: state_d = S_OUT_LUT;
      S_OUT_LUT: begin
        lut_addr_o = rect_w;
        state_d    = S_OUT_CMP;
      end
      S_OUT_CMP: begin
        acc_clr_w = 1'b1;
        if (take_w) begin
          best_val_d = lut_q_i;
          best_idx_d = out_idx_q;
        end
        if (out_idx_q == OUT_W'(N_OUT - 1)) begin
          digit_d = take_w ? out_idx_q : best_idx_q;
          state_d = S_DONE;
        end else begin
          out_idx_d = out_idx_q + OUT_W'(1);
          state_d   = S_OUT_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_idx_q   <= '0;
      hid_idx_q  <= '0;
      out_idx_q  <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_idx_q   <= in_idx_d;
      hid_idx_q  <= hid_idx_d;
      out_idx_q  <= out_idx_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      vld_q      <= (state_q == S_HID_MAC) || (state_q == S_OUT_MAC);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we_w) hid_ram_q[hid_idx_q] <= lut_q_i;
    hid_rd_q <= hid_ram_q[hid_idx_q];
  end

  assign digit_o = digit_q;
  assign done_o  = (state_q == S_DONE);
  assign busy_o  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snn_core_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snn_core_param : directed bench for small and default configs   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_snn_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, sel;
  logic start_s, start_d;
  assign start_s = start & ~sel;
  assign start_d = start & sel;

  // small 4-2-3 instance
  logic [1:0]  in_addr_s;  logic in_q_s;
  logic [2:0]  hw_addr_s;  logic [7:0] hw_q_s;
  logic [2:0]  ow_addr_s;  logic [7:0] ow_q_s;
  logic [10:0] lut_addr_s; logic [7:0] lut_q_s;
  logic [1:0]  digit_s;    logic done_s, busy_s;
  // default 784-32-10 instance
  logic [9:0]  in_addr_d;  logic in_q_d;
  logic [14:0] hw_addr_d;  logic [7:0] hw_q_d;
  logic [8:0]  ow_addr_d;  logic [7:0] ow_q_d;
  logic [10:0] lut_addr_d; logic [7:0] lut_q_d;
  logic [3:0]  digit_d;    logic done_d, busy_d;

  logic              pix_s [0:3];
  logic signed [7:0] hw_s  [0:7];
  logic signed [7:0] ow_s  [0:7];
  logic              pix_d [0:1023];
  logic signed [7:0] hw_d  [0:32767];
  logic signed [7:0] ow_d  [0:511];

  always @(posedge clk) begin
    in_q_s  <= pix_s[in_addr_s];
    hw_q_s  <= hw_s[hw_addr_s];
    ow_q_s  <= ow_s[ow_addr_s];
    lut_q_s <= lut_addr_s[10:3];
    in_q_d  <= pix_d[in_addr_d];
    hw_q_d  <= hw_d[hw_addr_d];
    ow_q_d  <= ow_d[ow_addr_d];
    lut_q_d <= lut_addr_d[10:3];
  end

  snn_core_param #(.N_IN(4), .N_HID(2), .N_OUT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start_s),
    .in_addr_o(in_addr_s), .in_q_i(in_q_s),
    .hw_addr_o(hw_addr_s), .hw_q_i(hw_q_s),
    .ow_addr_o(ow_addr_s), .ow_q_i(ow_q_s),
    .lut_addr_o(lut_addr_s), .lut_q_i(lut_q_s),
    .digit_o(digit_s), .done_o(done_s), .busy_o(busy_s));

  snn_core_param dut_d (
    .clk(clk), .rst_n(rst_n), .start_i(start_d),
    .in_addr_o(in_addr_d), .in_q_i(in_q_d),
    .hw_addr_o(hw_addr_d), .hw_q_i(hw_q_d),
    .ow_addr_o(ow_addr_d), .ow_q_i(ow_q_d),
    .lut_addr_o(lut_addr_d), .lut_q_i(lut_q_d),
    .digit_o(digit_d), .done_o(done_d), .busy_o(busy_d));

  logic        done_m, busy_m;
  logic [10:0] lut_m;
  logic [3:0]  digit_m;
  assign done_m  = sel ? done_d : done_s;
  assign busy_m  = sel ? busy_d : busy_s;
  assign lut_m   = sel ? lut_addr_d : lut_addr_s;
  assign digit_m = sel ? digit_d : {2'b00, digit_s};

  int checks, errors;
  int lut_log [1:26000];
  int done_at, dig_got, busy_n;

  typedef struct {
    int ow0, ow1, ow2;
    int pulse;
    int dig;
    int l0, l1, l2;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic set_small_ow(input int r0, input int r1, input int r2);
    for (int h = 0; h < 2; h++) begin
      ow_s[0*2+h] = 8'(r0);
      ow_s[1*2+h] = 8'(r1);
      ow_s[2*2+h] = 8'(r2);
    end
  endtask

  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run(input int exp_lat, input int pulse_at, input bit hold);
    int cnt;
    done_at = -1;
    busy_n  = 0;
    dig_got = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    cnt = 1;
    while (done_at < 0 && cnt <= exp_lat + 20) begin
      lut_log[cnt] = int'(lut_m);
      if (busy_m) busy_n++;
      if (done_m) begin
        done_at = cnt;
        dig_got = int'(digit_m);
      end else begin
        start = hold || (cnt == pulse_at);
        @(posedge clk); #1;
        cnt++;
      end
    end
  endtask

  function automatic int ref_addr(input longint acc);
    longint r;
    r = acc >>> 7;
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return int'(r + 1024);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, quiet, ref_dig, best;
    longint acc;
    int ha [32];
    int hv [32];
    int oa [10];
    checks = 0; errors = 0;
    start = 1'b0; sel = 1'b0; rst_n = 1'b1;

    vecs[0] = '{ow0:  1, ow1:  5, ow2: -3, pulse:  0, dig: 1, l0: 1026, l1: 1036, l2: 1016};
    vecs[1] = '{ow0:  1, ow1:  5, ow2:  5, pulse:  0, dig: 1, l0: 1026, l1: 1036, l2: 1036};
    vecs[2] = '{ow0:  5, ow1:  5, ow2: -3, pulse:  3, dig: 0, l0: 1036, l1: 1036, l2: 1016};
    vecs[3] = '{ow0: -3, ow1: -3, ow2:  1, pulse:  0, dig: 2, l0: 1016, l1: 1016, l2: 1026};
    vecs[4] = '{ow0:  0, ow1:  0, ow2:  0, pulse: 16, dig: 0, l0: 1024, l1: 1024, l2: 1024};
    vecs[5] = '{ow0: -2, ow1: 20, ow2: 19, pulse:  0, dig: 1, l0: 1019, l1: 1073, l2: 1071};

    for (int i = 0; i < 4; i++) pix_s[i] = 1'b1;
    for (int i = 0; i < 8; i++) begin hw_s[i] = 8'sh40; ow_s[i] = 8'sh00; end
    for (int i = 0; i < 32768; i++) hw_d[i] = 8'sh00;
    for (int i = 0; i < 1024; i++) pix_d[i] = 1'b0;
    for (int i = 0; i < 512; i++) ow_d[i] = 8'sh00;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_small", {busy_s, done_s, digit_s, lut_addr_s, in_addr_s, hw_addr_s, ow_addr_s}, 0);
    chk("reset_outs_dflt", {busy_d, done_d, digit_d, lut_addr_d, in_addr_d, hw_addr_d, ow_addr_d}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy_small", busy_s, 0);
    chk("idle_busy_dflt", busy_d, 0);

    for (int v = 0; v < 6; v++) begin
      set_small_ow(vecs[v].ow0, vecs[v].ow1, vecs[v].ow2);
      run(30, vecs[v].pulse, 1'b0);
      chk($sformatf("v%0d_done_cycle", v), done_at, 30);
      chk($sformatf("v%0d_busy_span", v), busy_n, 30);
      chk($sformatf("v%0d_digit", v), dig_got, vecs[v].dig);
      chk($sformatf("v%0d_hid0_lut", v), lut_log[6], 1278);
      chk($sformatf("v%0d_hid1_lut", v), lut_log[13], 1278);
      chk($sformatf("v%0d_out0_lut", v), lut_log[18], vecs[v].l0);
      chk($sformatf("v%0d_out1_lut", v), lut_log[23], vecs[v].l1);
      chk($sformatf("v%0d_out2_lut", v), lut_log[28], vecs[v].l2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_after_done", v), {busy_m, done_m}, 0);
      chk($sformatf("v%0d_digit_hold", v), digit_m, vecs[v].dig);
    end

    // start held high through DONE relaunches from IDLE
    set_small_ow(1, 5, -3);
    run(30, 0, 1'b1);
    chk("hold_done_cycle", done_at, 30);
    chk("hold_digit", dig_got, 1);
    @(posedge clk); #1;
    chk("hold_idle_gap", {busy_m, done_m}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_relaunch_busy", busy_m, 1);
    cnt = 1;
    while (!done_m && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("hold_second_latency", cnt, 30);
    @(posedge clk); #1;

    // reset asserted during OUT_MAC aborts the run
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_in_out_mac", ow_addr_s, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs_zero", {busy_s, done_s, digit_s, lut_addr_s, in_addr_s, hw_addr_s, ow_addr_s}, 0);
    @(negedge clk) rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_s || busy_s) quiet++;
    end
    chk("abort_no_done", quiet, 0);
    chk("abort_digit_zero", digit_s, 0);
    set_small_ow(-2, 20, 19);
    run(30, 0, 1'b0);
    chk("abort_rerun_cycle", done_at, 30);
    chk("abort_rerun_digit", dig_got, 1);
    chk("abort_rerun_out1", lut_log[23], 1073);
    @(posedge clk); #1;

    // full-size run: neuron 0 saturates high, neuron 1 saturates low
    sel = 1'b1;
    for (int i = 0; i < 784; i++) pix_d[i] = 1'($urandom_range(1, 0));
    for (int h = 0; h < 32; h++)
      for (int i = 0; i < 784; i++)
        hw_d[h*1024+i] = (h == 0) ? 8'sd127 :
                         (h == 1) ? -8'sd128 : 8'(int'($urandom_range(16, 0)) - 8);
    for (int j = 0; j < 10; j++)
      for (int h = 0; h < 32; h++)
        ow_d[j*32+h] = 8'(int'($urandom_range(16, 0)) - 8);
    for (int h = 0; h < 32; h++) begin
      acc = 0;
      for (int i = 0; i < 784; i++)
        if (pix_d[i]) acc += 127 * longint'(hw_d[h*1024+i]);
      ha[h] = ref_addr(acc);
      hv[h] = ha[h] >> 3;
    end
    ref_dig = 0; best = -1;
    for (int j = 0; j < 10; j++) begin
      acc = 0;
      for (int h = 0; h < 32; h++) acc += longint'(hv[h]) * longint'(ow_d[j*32+h]);
      oa[j] = ref_addr(acc);
      if (j == 0 || (oa[j] >> 3) > best) begin
        best = oa[j] >> 3;
        ref_dig = j;
      end
    end
    run(25535, 0, 1'b0);
    chk("full_done_cycle", done_at, 25535);
    chk("full_busy_span", busy_n, 25535);
    chk("full_digit", dig_got, ref_dig);
    chk("full_sat_pos", lut_log[786], 2047);
    chk("full_sat_neg", lut_log[786+787], 0);
    for (int h = 2; h < 32; h++)
      chk($sformatf("full_hid%0d_lut", h), lut_log[h*787+786], ha[h]);
    for (int j = 0; j < 10; j++)
      chk($sformatf("full_out%0d_lut", j), lut_log[25184+j*35+34], oa[j]);
    @(posedge clk); #1;
    chk("full_after_done", {busy_m, done_m}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snn_core_param.md
# snn_core_param

Parametrised successor to the fixed 784-32-10 SNN core. It runs one inference of a two-layer, fully connected network over binary input pixels: a hidden layer of MAC, rectify and activation LUT, then an output layer of MAC, rectify and LUT, then an argmax. It reports the winning class index. Layer sizes, weight width and accumulator width are parameters, and every memory except the internal hidden-value RAM is external with a 1-cycle synchronous read. The argmax, tie rule and busy flag are new relative to the fixed core.

## Interface
- `N_IN`, 784: input units (binary pixels).
- `N_HID`, 32: hidden neurons.
- `N_OUT`, 10: output classes; `OUT_W = $clog2(N_OUT)`.
- `W_W`, 8: signed weight width; also the LUT data width.
- `ACC_W`, 26: signed accumulator width.
- `FRAC`, 7: accumulator LSBs dropped before the LUT.
- `LUT_AW`, 11: activation LUT address width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `start`  in  1  begin inference; sampled only in IDLE.
- `in_addr`  out  $clog2(N_IN)  input RAM address.
- `in_q`  in  1  pixel, valid 1 cycle after `in_addr`.
- `hw_addr`  out  $clog2(N_HID)+$clog2(N_IN)  hidden ROM address `{hid_idx, in_idx}`.
- `hw_q`  in  W_W  signed hidden weight, 1-cycle latency.
- `ow_addr`  out  OUT_W+$clog2(N_HID)  output ROM address `{out_idx, hid_idx}`.
- `ow_q`  in  W_W  signed output weight, 1-cycle latency.
- `lut_addr`  out  LUT_AW  activation LUT address.
- `lut_q`  in  W_W  unsigned activation, 1-cycle latency.
- `digit`  out  OUT_W  winning class; holds until the next done.
- `done`  out  1  one-cycle pulse at inference end.
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle.

## Operation
- States: IDLE → HID_MAC → HID_DRAIN → HID_LUT → HID_WR, looping over hidden neurons. Then OUT_MAC → OUT_DRAIN → OUT_LUT → OUT_CMP, looping over outputs. Then DONE → IDLE.
- IDLE: clears all counters and the accumulator. `start`=1 moves to HID_MAC. `start` is ignored in every other state.
- HID_MAC, N_IN cycles: addresses in_idx 0..N_IN-1 are issued.
  - Operand a = `in_q` ? 8'h7F : 8'h00.
  - Operand b = `hw_q`.
  - acc += a*b (signed), registered one cycle after the address.
- HID_DRAIN: last product accumulates.
- HID_LUT: `lut_addr` is driven from the accumulator.
- HID_WR: writes `lut_q` into hidden RAM[hid_idx] and clears acc. If hid_idx == N_HID-1, go to OUT_MAC with hid_idx cleared; else hid_idx++ and return to HID_MAC.
- OUT_MAC, N_HID cycles: operand a = hidden RAM read, registered with 1-cycle latency; operand b = `ow_q`.
- OUT_DRAIN and OUT_LUT: same as the hidden layer.
- OUT_CMP: compare `lut_q` (unsigned) with best.
  - out_idx 0 always loads best.
  - Otherwise replace only if strictly greater, so ties keep the lowest index.
  - If out_idx == N_OUT-1, go to DONE; else out_idx++ and return to OUT_MAC.
- DONE: `digit` ← best index, `done`=1, `busy`=1 for this cycle; next state IDLE.
- Rectify (combinational):
  - If acc[ACC_W-1:FRAC+LUT_AW-1] is not all-equal, saturate: positive → +max (11'h3FF), negative → -min (11'h400).
  - Otherwise use r = acc[FRAC+LUT_AW-1:FRAC].
  - `lut_addr` = r + 2^(LUT_AW-1), i.e. MSB flipped, so signed maps onto 0..2^LUT_AW-1.
- Outputs not driven by the active state are held at 0: `in_addr`, `hw_addr`, `ow_addr`, `lut_addr`.

## Timing
- Reset values: state IDLE; `digit`=0, `done`=0, `busy`=0; all address outputs 0; acc and best 0. Hidden RAM contents are not reset.
- `rst_n` low mid-inference aborts immediately. After release the block sits in IDLE; no `done` pulse; `digit` is 0.
- Latency from the edge that samples `start` to the `done` cycle: N_HID·(N_IN+3) + N_OUT·(N_HID+3) + 1. Defaults give 25 535 cycles.
- `start` held high through DONE launches a new inference on the cycle after DONE, i.e. back in IDLE.
- Counter wrap never occurs; terminal values are compared explicitly.

## Structure
- Package `snn_pkg` holds:
  - the state enum `snn_state_t`;
  - the pixel-high constant 8'h7F;
  - a function `snn_rectify(acc)` that returns `lut_addr`.
- Sub-module `snn_mac`, parametrised by W_W and ACC_W: signed multiply-accumulate with synchronous clear and enable.
- The hidden RAM is an inferred N_HID×W_W array inside the core.

## Test plan
- Reset: assert `rst_n`=0 at any point → all outputs 0, state IDLE; release → `busy`=0 until `start`.
- N_IN=4, N_HID=2, N_OUT=3; pixels all 1; hidden weights all 8'h40; LUT model returns addr[10:3].
  - acc = 4·127·64 = 32 512; `lut_addr` = 254+1024 = 1278; hidden value 159.
  - Verify `lut_addr` and the exact `done` cycle: 2·7+3·5+1 = 30.
- Argmax, small config: output weight rows 0/1/2 = +1/+5/-3 → `digit`=1. Rows 1 and 2 equal and maximal → `digit`=1 (tie goes to the lowest index).
- Saturation, default sizes: pixels all 1, weights 127 → `lut_addr`=11'h7FF. Weights -128 → `lut_addr`=11'h000.
- `start` pulsed mid-HID_MAC → ignored, latency unchanged. `rst_n` pulsed mid-OUT_MAC → no `done`; a new `start` completes normally with the correct `digit`.
- Full 784-32-10 run against a reference model: `digit` matches, `done` exactly 25 535 cycles after `start`, `busy` high for exactly that span.
